// File: rtl/ds_share_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : ds_share_arb_pkg
//  Purpose : Shared constants for the display-sharing arbiter: FSM state
//            codes, data/digit widths and the owner index width.
//  Ports   : none (package)
//  Config  : none
//  Revision: 1.0  initial release
// ============================================================================
package ds_share_arb_pkg;

    // FSM state codes
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SHOW = 1'b1;

    // Producer value width and seven-segment digit width
    localparam int DATA_W = 16;
    localparam int DIG_W  = 4;

    // Owner index width (covers up to 8 requesters)
    localparam int IDX_W  = 3;

endpackage : ds_share_arb_pkg
`default_nettype wire

// File: rtl/ds_share_arb_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module  : rr_pick
//  Purpose : Combinational round-robin picker. Searches last+1, last+2, ...
//            modulo NREQ for the first asserted request, so the previous
//            owner is always searched last.
//  Ports   : req   in  NREQ  level requests
//            last  in  3     index of previous owner
//            pick  out NREQ  one-hot winner (zero when req == 0)
//            index out 3     index of winner (zero when req == 0)
//  Config  : DS_ARB_PRIO_EN - when defined, source 0 wins any pick it is in.
//  Revision: 1.0  initial release
// ============================================================================
module rr_pick
    import ds_share_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last,
    output logic [NREQ-1:0]  pick,
    output logic [IDX_W-1:0] index
);

    logic w_found;
    int   w_pos;

    always_comb begin
        pick    = '0;
        index   = '0;
        w_found = 1'b0;
        w_pos   = 0;
        // k = NREQ lands back on 'last' itself, making it the final candidate
        for (int k = 1; k <= NREQ; k++) begin
            w_pos = (int'(last) + k) % NREQ;
            if (!w_found && req[w_pos]) begin
                w_found     = 1'b1;
                pick[w_pos] = 1'b1;
                index       = IDX_W'(w_pos);
            end
        end
`ifdef DS_ARB_PRIO_EN
        if (req[0]) begin
            pick  = NREQ'(1);
            index = '0;
        end
`endif
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/ds_share_arb.sv
`default_nettype none
// ============================================================================
//  Module  : ds_share_arb
//  Purpose : Time-shares the 4-digit seven-segment display between NREQ
//            producers. Grants round-robin, holds each owner for HOLD_CYC
//            cycles, refreshes digits live from the owner, then hands over
//            with no gap cycle. Drives dt_module num1..num4.
//  Ports   : clk       in  1        system clock, posedge
//            rst_n     in  1        synchronous reset, active low
//            req       in  NREQ     level request per source
//            req_data  in  16*NREQ  source i value in [16*i+15:16*i]
//            gnt       out NREQ     one-hot, one-cycle pulse on new grant
//            owner     out 3        current/last owner index
//            busy      out 1        owner inside hold window
//            num1..4   out 4 each   owner data nibbles 0..3
//  Config  : DS_ARB_PRIO_EN - when defined, source 0 preempts any other
//            owner at the next edge and wins every pick it takes part in.
//  Revision: 1.0  initial release
// ============================================================================
module ds_share_arb
    import ds_share_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int HOLD_CYC = 48000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [DATA_W*NREQ-1:0] req_data,
    output logic [NREQ-1:0]        gnt,
    output logic [IDX_W-1:0]       owner,
    output logic                   busy,
    output logic [DIG_W-1:0]       num1,
    output logic [DIG_W-1:0]       num2,
    output logic [DIG_W-1:0]       num3,
    output logic [DIG_W-1:0]       num4
);

    localparam int               CNT_W    = $clog2(HOLD_CYC);
    localparam logic [CNT_W-1:0] c_RELOAD = CNT_W'(HOLD_CYC - 1);
    localparam logic [IDX_W-1:0] c_LAST0  = IDX_W'(NREQ - 1);

    // Registered state and outputs
    logic [0:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_owner;
    logic [NREQ-1:0]   r_gnt;
    logic              r_busy;
    logic [DATA_W-1:0] r_num;

    // Combinational next values
    logic [0:0]        w_state_nxt;
    logic              w_grant;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [IDX_W-1:0]  w_owner_nxt;
    logic [NREQ-1:0]   w_gnt_nxt;
    logic              w_busy_nxt;
    logic [DATA_W-1:0] w_num_nxt;

    // Picker results and data muxes
    logic [NREQ-1:0]   w_pick;
    logic [IDX_W-1:0]  w_pick_idx;
    logic              w_req_own;
    logic [DATA_W-1:0] w_own_data;
    logic [DATA_W-1:0] w_pick_data;

    // The picker always starts after the current/last owner
    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req   (req),
        .last  (r_owner),
        .pick  (w_pick),
        .index (w_pick_idx)
    );

    // Index-to-data muxes written as compares so the 3-bit index can address
    // any NREQ without out-of-range selects
    always_comb begin
        w_req_own   = 1'b0;
        w_own_data  = '0;
        w_pick_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_owner == IDX_W'(i)) begin
                w_req_own  = req[i];
                w_own_data = req_data[DATA_W*i +: DATA_W];
            end
            if (w_pick_idx == IDX_W'(i)) begin
                w_pick_data = req_data[DATA_W*i +: DATA_W];
            end
        end
    end

    // ---------------- state register (all outputs registered) -------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_owner <= c_LAST0;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_num   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_owner <= w_owner_nxt;
            r_gnt   <= w_gnt_nxt;
            r_busy  <= w_busy_nxt;
            r_num   <= w_num_nxt;
        end
    end

    // ---------------- next-state logic ------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_SHOW;
                end
            end
            ST_SHOW: begin
                // Hold end: any pending request (including the owner's own)
                // is granted in the same edge, otherwise fall back to idle
                if (r_cnt == '0) begin
                    if (|req) begin
                        w_grant = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
`ifdef DS_ARB_PRIO_EN
                else if ((r_owner != '0) && req[0]) begin
                    w_grant = 1'b1;
                end
`endif
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- output logic (next values of registered outputs) ----
    always_comb begin
        w_gnt_nxt   = '0;
        w_owner_nxt = r_owner;
        w_num_nxt   = r_num;
        w_cnt_nxt   = r_cnt;
        w_busy_nxt  = (w_state_nxt == ST_SHOW);
        if (w_grant) begin
            w_gnt_nxt   = w_pick;
            w_owner_nxt = w_pick_idx;
            w_num_nxt   = w_pick_data;
            w_cnt_nxt   = c_RELOAD;
        end else if (r_state == ST_SHOW) begin
            // Live refresh touches only the digits, never the hold counter
            if (w_req_own) begin
                w_num_nxt = w_own_data;
            end
            if (r_cnt != '0) begin
                w_cnt_nxt = r_cnt - 1'b1;
            end
        end
    end

    assign gnt   = r_gnt;
    assign owner = r_owner;
    assign busy  = r_busy;
    assign num1  = r_num[DIG_W*0 +: DIG_W];
    assign num2  = r_num[DIG_W*1 +: DIG_W];
    assign num3  = r_num[DIG_W*2 +: DIG_W];
    assign num4  = r_num[DIG_W*3 +: DIG_W];

endmodule : ds_share_arb
`default_nettype wire
